multicycle_fsm: RTL and testbench

Main control state machine for the multicycle MIPS-subset CPU. It sequences the shared datapath (single memory port, one ALU, IR/A/B/ALUOut/MDR registers) through fetch, decode, execute, memory and writeback steps, one instruction at a time. It decodes `op`/`func` into per-cycle enables and mux selects, waits on a memory-ready handshake, and counts retired instructions. It sits between the IR and the datapath; the datapath registers remain outside this block.

---
 rtl/multicycle_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_fsm.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_fsm.sv
`default_nettype none
// ============================================================================
// Module : multicycle_fsm
// Main control FSM for a multicycle MIPS-subset CPU datapath.
// Rev    : 1.0  initial release
// ============================================================================
module multicycle_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  aluc,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        done,
  output logic        illegal,
  output logic [31:0] retire_count
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC_R = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_EXEC_I = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b1001;

  logic [3:0]  r_state;
  logic [3:0]  w_next;
  logic        r_illegal;
  logic [31:0] r_count;
  logic        w_pc_write;
  logic        w_pc_write_cond;
  logic        w_r_valid;
  logic [3:0]  w_r_aluc;

  always_comb begin
    w_r_valid = 1'b1;
    w_r_aluc  = 4'b0000;
    case (func)
      FN_ADD:  w_r_aluc = ALU_ADD;
      FN_SUB:  w_r_aluc = ALU_SUB;
      FN_AND:  w_r_aluc = ALU_AND;
      FN_OR:   w_r_aluc = ALU_OR;
      FN_XOR:  w_r_aluc = ALU_XOR;
      default: w_r_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_count   <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_next == S_HALT)
        r_illegal <= 1'b1;
      if (done)
        r_count <= r_count + 32'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     w_next = w_r_valid ? S_EXEC_R : S_HALT;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_EXEC_I;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_HALT;
        endcase
      end
      S_MEMADR: w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC_R: w_next = S_RWB;
      S_EXEC_I: w_next = S_IWB;
      S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      // Unused encodings park in HALT rather than run on with garbage control
      default:  w_next = S_HALT;
    endcase
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    ir_write        = 1'b0;
    i_or_d          = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    reg_write       = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    aluc            = 4'b0000;
    pc_source       = 2'b00;
    done            = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = 2'b01;
          aluc       = ALU_ADD;
          ir_write   = mem_ready;
          w_pc_write = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          aluc      = ALU_ADD;
        end
        S_MEMADR, S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluc      = ALU_ADD;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          done       = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          done      = mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          aluc      = w_r_aluc;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          done      = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a       = 1'b1;
          aluc            = ALU_SUB;
          pc_source       = 2'b01;
          w_pc_write_cond = 1'b1;
          done            = 1'b1;
        end
        S_IWB: begin
          reg_write = 1'b1;
          done      = 1'b1;
        end
        S_JUMP: begin
          w_pc_write = 1'b1;
          pc_source  = 2'b10;
          done       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en        = w_pc_write | (w_pc_write_cond & zero);
  assign state        = rst ? 4'd0 : r_state;
  assign illegal      = ~rst & r_illegal;
  assign retire_count = rst ? 32'd0 : r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_fsm.sv
`default_nettype none
// Bench for multicycle_fsm: directed scenarios followed by a random instruction
// stream, each cycle compared against a per-instruction phase model.
module tb_multicycle_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_to_reg, alu_src_a, done, illegal;
  logic [1:0]  alu_src_b, pc_source;
  logic [3:0]  aluc, state;
  logic [31:0] retire_count;

  multicycle_fsm dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluc(aluc), .pc_source(pc_source), .state(state), .done(done),
    .illegal(illegal), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] aluc;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       done, illegal;
  } outv_t;

  outv_t       obs;
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model_count = 32'd0;

  assign obs = {pc_en, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, aluc, pc_source, state, done, illegal};

  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_ILL = 6;

  function automatic logic [3:0] r_aluc(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100110: return 4'b1001;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'b000000)
      return (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110}) ? C_R : C_ILL;
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  // Output table for one cycle spent in a given step of an instruction
  function automatic outv_t exp_out(input int st, input bit rdy, input bit z, input logic [5:0] f);
    outv_t e;
    e = '0;
    e.state = st[3:0];
    case (st)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.aluc = 4'b0010;
                e.ir_write = rdy; e.pc_en = rdy; end
      1:  begin e.alu_src_b = 2'b11; e.aluc = 4'b0010; end
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.aluc = 4'b0010; end
      3:  begin e.mem_read = 1; e.i_or_d = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.done = 1; end
      5:  begin e.mem_write = 1; e.i_or_d = 1; e.done = rdy; end
      6:  begin e.alu_src_a = 1; e.aluc = r_aluc(f); end
      7:  begin e.reg_write = 1; e.reg_dst = 1; e.done = 1; end
      8:  begin e.alu_src_a = 1; e.aluc = 4'b0110; e.pc_source = 2'b01;
                e.pc_en = z; e.done = 1; end
      9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.aluc = 4'b0010; end
      10: begin e.reg_write = 1; e.done = 1; end
      11: begin e.pc_en = 1; e.pc_source = 2'b10; e.done = 1; end
      15: e.illegal = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input int st, input bit rdy, input int zf, input string tag);
    outv_t e;
    mem_ready = rdy;
    zero = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
    @(negedge clk);
    e = exp_out(st, rdy, zero, func);
    check($sformatf("%s st%0d outputs", tag, st), 32'(obs), 32'(e));
    check($sformatf("%s st%0d retire_count", tag, st), retire_count, model_count);
    if (e.done) model_count = model_count + 32'd1;
    @(posedge clk); #1;
  endtask

  task automatic wstep(input int st, input int nwait, input int zf, input string tag);
    for (int k = 0; k < nwait; k++) step(st, 1'b0, zf, tag);
    step(st, 1'b1, zf, tag);
  endtask

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input int ncyc, input string tag);
    rst = 1'b1;
    for (int k = 0; k < ncyc; k++) begin
      mem_ready = rnd_bit();
      zero      = rnd_bit();
      @(negedge clk);
      check($sformatf("%s rst outputs", tag), 32'(obs), 32'd0);
      check($sformatf("%s rst retire_count", tag), retire_count, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    model_count = 32'd0;
  endtask

  // fw/mw < 0 selects a random wait count of 0..2
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw,
                           input int mw, input int zf, input string tag);
    int w_f, w_m;
    op   = o;
    func = f;
    w_f  = (fw < 0) ? int'($urandom_range(0, 2)) : fw;
    w_m  = (mw < 0) ? int'($urandom_range(0, 2)) : mw;
    wstep(0, w_f, zf, tag);
    step(1, rnd_bit(), zf, tag);
    case (classify(o, f))
      C_R:    begin step(6, rnd_bit(), zf, tag); step(7, rnd_bit(), zf, tag); end
      C_LW:   begin step(2, rnd_bit(), zf, tag); wstep(3, w_m, zf, tag);
                    step(4, rnd_bit(), zf, tag); end
      C_SW:   begin step(2, rnd_bit(), zf, tag); wstep(5, w_m, zf, tag); end
      C_BEQ:  step(8, rnd_bit(), zf, tag);
      C_ADDI: begin step(9, rnd_bit(), zf, tag); step(10, rnd_bit(), zf, tag); end
      C_J:    step(11, rnd_bit(), zf, tag);
      default: for (int k = 0; k < 10; k++) step(15, rnd_bit(), zf, tag);
    endcase
  endtask

  initial begin
    logic [5:0] ro, rf;
    int r;
    logic [5:0] rfuncs [5];
    logic [5:0] lops [5];
    rfuncs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110};
    lops   = '{6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    op = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b1; rst = 1'b1;
    do_reset(3, "init");

    run_instr(6'b000000, 6'b100000, 0, 0, -1, "add");
    run_instr(6'b100011, 6'd0, 0, 2, -1, "lw_wait");
    run_instr(6'b000100, 6'd0, 0, 0, 1, "beq_taken");
    run_instr(6'b000100, 6'd0, 0, 0, 0, "beq_not");
    run_instr(6'b111111, 6'd0, 0, 0, -1, "illegal");
    do_reset(1, "halt_exit");

    // sw aborted by reset while the store is still waiting
    op = 6'b101011; func = 6'd0;
    step(0, 1'b1, -1, "sw_abort");
    step(1, 1'b1, -1, "sw_abort");
    step(2, 1'b1, -1, "sw_abort");
    step(5, 1'b0, -1, "sw_abort");
    mem_ready = 1'b0;
    do_reset(1, "sw_abort");
    run_instr(6'b001000, 6'd5, 0, 0, -1, "addi_after_abort");

    for (int i = 0; i < 250; i++) begin
      r  = int'($urandom_range(0, 99));
      rf = 6'($urandom);
      if (r < 4) begin
        do ro = 6'($urandom); while (classify(ro, rf) != C_ILL);
        run_instr(ro, rf, -1, -1, -1, $sformatf("rnd%0d", i));
        do_reset(int'($urandom_range(1, 2)), $sformatf("rnd%0d", i));
      end else if (r < 40) begin
        run_instr(6'b000000, rfuncs[$urandom_range(0, 4)], -1, -1, -1, $sformatf("rnd%0d", i));
      end else begin
        run_instr(lops[$urandom_range(0, 4)], rf, -1, -1, -1, $sformatf("rnd%0d", i));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
